// File: rtl/fetch_pkg.sv
// Shared fetch constants and types.
// Imported by the fetch unit and its buffer.
package fetch_pkg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x 64 FIFO.
// Flush empties it; a simultaneous push is dropped.
module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [63:0] wdata,
  input  logic        pop,
  input  logic        flush,
  output logic [63:0] rdata,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0] mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];

  // Storage write; pointers below decide visibility.
  always_ff @(posedge clk) begin
    if (push && !flush)
      mem[wp[AW-1:0]] <= wdata;
  end

  // Pointer update; flush returns both to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC sequencing, redirect, buffer.
// One instruction per cycle into fetch_fifo.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        misalign
);

  localparam logic [31:0] PC0 =
    {RESET_PC[31:2], 2'b00};

  state_t       state;
  logic [31:0]  pc;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;
  logic         redir;
  fetch_entry_t wentry;
  fetch_entry_t head;

  assign imem_addr = {pc[31:2], 2'b00};

  // Handshake and push/redirect qualification.
  always_comb begin
    pop   = !empty && instr_ready;
    redir = (state == RUN) && redirect_valid;
    push  = (state == RUN) && !redirect_valid &&
            (!full || pop);
    wentry.pc    = imem_addr;
    wentry.instr = imem_rdata;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(wentry),
    .pop  (pop),
    .flush(redir),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

  // Head presentation; NOP at reset PC when empty.
  always_comb begin
    instr_valid = !empty;
    instr       = empty ? NOP : head.instr;
    instr_pc    = empty ? PC0 : head.pc;
  end

  // Boot/run sequencing, PC and misalign pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= PC0;
      misalign <= 1'b0;
    end else begin
      unique case (state)
        BOOT: begin
          state    <= RUN;
          misalign <= 1'b0;
        end
        RUN: begin
          misalign <= redir && (redirect_pc[1:0] != 2'b00);
          if (redir)
            pc <= {redirect_pc[31:2], 2'b00};
          else if (push)
            pc <= imem_addr + WORD_BYTES;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Memory returns addr ^ A5A5_0000.
module tb_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  int n_chk = 0;
  int n_ok  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  fetch_unit #(
    .RESET_PC(32'h0),
    .DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .misalign      (misalign)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag,
                      input logic [31:0] pc);
    chk({tag, ".v"}, {31'b0, instr_valid}, 32'd1);
    chk({tag, ".pc"}, instr_pc, pc);
    chk({tag, ".in"}, instr, pc ^ KEY);
  endtask

  initial begin
    #2;
    chk("rst.v", {31'b0, instr_valid}, 32'd0);
    chk("rst.mis", {31'b0, misalign}, 32'd0);
    chk("rst.in", instr, 32'h13);
    chk("rst.pc", instr_pc, 32'h0);
    chk("rst.addr", imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // boot cycle, then stream 0,4,8,12
    step();
    chk("boot.v", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      head("seq", 32'(i * 4));
    end

    // stall: fill to DEPTH, pc frozen at 0x14
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("stall", 32'hC);
      chk("stall.addr", imem_addr, 32'h14);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      head("drain", 32'(16 + i * 4));
    end

    // full buffer, pop + redirect same edge
    head("popd", 32'h18);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("fl.v", {31'b0, instr_valid}, 32'd0);
    chk("fl.addr", imem_addr, 32'h100);
    chk("fl.mis", {31'b0, misalign}, 32'd0);
    step();
    head("r100", 32'h100);

    // misaligned target
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk("mis.1", {31'b0, misalign}, 32'd1);
    step();
    chk("mis.0", {31'b0, misalign}, 32'd0);
    head("r102", 32'h100);

    // wrap at top of address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    head("wrap0", 32'hFFFF_FFFC);
    step();
    head("wrap1", 32'h0);
    step();
    head("wrap2", 32'h4);

    // async reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("ar.v", {31'b0, instr_valid}, 32'd0);
    chk("ar.in", instr, 32'h13);
    chk("ar.pc", instr_pc, 32'h0);
    chk("ar.addr", imem_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("ar.boot", {31'b0, instr_valid}, 32'd0);
    step();
    head("ar.s0", 32'h0);
    step();
    head("ar.s1", 32'h4);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
